// File: rtl/battery_ctrl_pkg.sv
// Shared constants for the charge/discharge supervisor: FSM state codes, duty ceiling
// and the SOC thermometer thresholds.
package battery_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCharge    = 3'd1,
    StTopoff    = 3'd2,
    StDischarge = 3'd3,
    StFault     = 3'd4
  } state_e;

  localparam logic [7:0] PCT_MAX = 8'd100;

  localparam logic [7:0] LED_THRESH [8] = '{
    8'd12, 8'd25, 8'd37, 8'd50, 8'd62, 8'd75, 8'd87, 8'd100
  };

  function automatic logic [7:0] led_bar(input logic [7:0] s);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i] = (s >= LED_THRESH[i]);
    end
    return res;
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// One duty channel: steps 1 %/tick toward its target, can be blocked from rising
// (break-before-make) and is zeroed at once by force_zero.
module duty_ramp
  import battery_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] target,
  input  logic       hold_up,
  input  logic       force_zero,
  output logic [7:0] duty
);

  logic [7:0] tgt;
  logic [7:0] duty_d, duty_q;

  assign tgt = (target > PCT_MAX) ? PCT_MAX : target;

  always_comb begin
    duty_d = duty_q;
    if (force_zero) begin
      duty_d = '0;
    end else if (tick) begin
      if (duty_q < tgt && !hold_up) begin
        duty_d = duty_q + 8'd1;
      end else if (duty_q > tgt) begin
        duty_d = duty_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty = duty_q;

endmodule

// File: rtl/charge_duty_ctrl.sv
// Charge / top-off / discharge supervisor producing slew-limited duty commands for
// the charger (d1) and load (d2) legs of the downstream pwm block.
module charge_duty_ctrl
  import battery_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned RAMP_HZ  = 1000,
  parameter int unsigned SOC_LOW  = 20,
  parameter int unsigned SOC_HIGH = 95,
  parameter int unsigned SOC_FULL = 100,
  parameter int unsigned HYST     = 5,
  parameter int unsigned D1_MAX   = 90,
  parameter int unsigned D1_TOP   = 30,
  parameter int unsigned D2_MAX   = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] soc,
  input  logic       soc_valid,
  input  logic       en,
  input  logic       load_req,
  input  logic       fault_in,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [2:0] state,
  output logic       low_batt,
  output logic [7:0] led
);

  localparam int unsigned TICK_DIV = CLK_HZ / RAMP_HZ;
  localparam int unsigned CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [7:0] SocLow    = 8'(SOC_LOW);
  localparam logic [7:0] SocLowClr = 8'(SOC_LOW + HYST);
  localparam logic [7:0] SocHigh   = 8'(SOC_HIGH);
  localparam logic [7:0] SocReChg  = 8'(SOC_HIGH - HYST);
  localparam logic [7:0] SocFull   = 8'(SOC_FULL);
  localparam logic [7:0] D1Max     = 8'(D1_MAX);
  localparam logic [7:0] D1Top     = 8'(D1_TOP);
  localparam logic [7:0] D2Max     = 8'(D2_MAX);

  logic [CntW-1:0] presc_q;
  logic            tick;
  logic [7:0]      soc_q;
  logic            have_sample_q;
  state_e          state_d, state_q;
  logic            low_batt_d, low_batt_q;
  logic [7:0]      d1_tgt, d2_tgt;
  logic            force_zero;
  logic            d1_hold, d2_hold;

  // Prescaler
  assign tick = (presc_q == CntW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // SOC capture, clamped to 100 %
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soc_q         <= '0;
      have_sample_q <= 1'b0;
    end else if (soc_valid) begin
      soc_q         <= (soc > PCT_MAX) ? PCT_MAX : soc;
      have_sample_q <= 1'b1;
    end
  end

  // Next-state logic; priority is fault, then enable, then load request, then SOC
  always_comb begin
    state_d    = state_q;
    low_batt_d = low_batt_q;
    if (fault_in) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en && have_sample_q) begin
            if (load_req) begin
              if (!low_batt_q && soc_q > SocLow) state_d = StDischarge;
            end else if (soc_q < SocHigh) begin
              state_d = StCharge;
            end else if (soc_q < SocFull) begin
              state_d = StTopoff;
            end
          end
        end
        StCharge: begin
          if (!en || load_req)      state_d = StIdle;
          else if (soc_q >= SocHigh) state_d = StTopoff;
        end
        StTopoff: begin
          if (!en || load_req || soc_q >= SocFull) state_d = StIdle;
          else if (soc_q < SocReChg)               state_d = StCharge;
        end
        StDischarge: begin
          if (!en || !load_req) begin
            state_d = StIdle;
          end else if (soc_q <= SocLow) begin
            state_d    = StIdle;
            low_batt_d = 1'b1;
          end
        end
        StFault: begin
          if (!en) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    if (soc_q >= SocLowClr) low_batt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      low_batt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_batt_q <= low_batt_d;
    end
  end

  // Targets follow the registered state so a same-cycle crossing ramps toward the old target
  always_comb begin
    d1_tgt = '0;
    d2_tgt = '0;
    unique case (state_q)
      StCharge:    d1_tgt = D1Max;
      StTopoff:    d1_tgt = D1Top;
      StDischarge: d2_tgt = D2Max;
      default: begin
        d1_tgt = '0;
        d2_tgt = '0;
      end
    endcase
  end

  assign force_zero = (state_d == StFault);
  assign d1_hold    = (d2 != 8'd0);
  assign d2_hold    = (d1 != 8'd0);

  duty_ramp u_ramp_d1 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .target     (d1_tgt),
    .hold_up    (d1_hold),
    .force_zero (force_zero),
    .duty       (d1)
  );

  duty_ramp u_ramp_d2 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .target     (d2_tgt),
    .hold_up    (d2_hold),
    .force_zero (force_zero),
    .duty       (d2)
  );

  assign state    = state_q;
  assign low_batt = low_batt_q;
  assign led      = led_bar(soc_q);

endmodule

// File: tb/tb_charge_duty_ctrl.sv
// Self-checking bench for charge_duty_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the supervisor.
module tb_charge_duty_ctrl;

  localparam int TICK = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] soc;
  logic       soc_valid;
  logic       en;
  logic       load_req;
  logic       fault_in;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [2:0] state;
  logic       low_batt;
  logic [7:0] led;

  int n_chk  = 0;
  int n_fail = 0;

  charge_duty_ctrl #(
    .CLK_HZ  (1000),
    .RAMP_HZ (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .soc       (soc),
    .soc_valid (soc_valid),
    .en        (en),
    .load_req  (load_req),
    .fault_in  (fault_in),
    .d1        (d1),
    .d2        (d2),
    .state     (state),
    .low_batt  (low_batt),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  int m_soc, m_have, m_cyc, m_state, m_low, m_d1, m_d2;

  function automatic int led_of(input int s);
    int th[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    int r = 0;
    for (int i = 0; i < 8; i++) if (s >= th[i]) r += (1 << i);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int  ns, nlow, t1, t2, n1, n2;
    bit  tk;
    if (rst) begin
      m_soc <= 0; m_have <= 0; m_cyc <= 0; m_state <= 0; m_low <= 0; m_d1 <= 0; m_d2 <= 0;
    end else begin
      tk   = ((m_cyc % TICK) == TICK - 1);
      ns   = m_state;
      nlow = m_low;
      if (fault_in) ns = 4;
      else if (m_state == 0) begin
        if (en && m_have != 0) begin
          if (load_req) begin
            if (m_low == 0 && m_soc > 20) ns = 3;
          end else if (m_soc < 95) ns = 1;
          else if (m_soc < 100) ns = 2;
        end
      end else if (m_state == 1) begin
        if (!en || load_req) ns = 0;
        else if (m_soc >= 95) ns = 2;
      end else if (m_state == 2) begin
        if (!en || load_req || m_soc >= 100) ns = 0;
        else if (m_soc < 90) ns = 1;
      end else if (m_state == 3) begin
        if (!en || !load_req) ns = 0;
        else if (m_soc <= 20) begin ns = 0; nlow = 1; end
      end else if (!en) ns = 0;
      if (m_soc >= 25) nlow = 0;
      t1 = (m_state == 1) ? 90 : (m_state == 2) ? 30 : 0;
      t2 = (m_state == 3) ? 80 : 0;
      n1 = m_d1;
      n2 = m_d2;
      if (ns == 4) begin
        n1 = 0; n2 = 0;
      end else if (tk) begin
        if (m_d1 < t1 && m_d2 == 0) n1 = m_d1 + 1; else if (m_d1 > t1) n1 = m_d1 - 1;
        if (m_d2 < t2 && m_d1 == 0) n2 = m_d2 + 1; else if (m_d2 > t2) n2 = m_d2 - 1;
      end
      m_cyc   <= m_cyc + 1;
      m_state <= ns;
      m_low   <= nlow;
      m_d1    <= n1;
      m_d2    <= n2;
      if (soc_valid) begin
        m_soc  <= (int'(soc) > 100) ? 100 : int'(soc);
        m_have <= 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("d1", d1, m_d1);
      chk("d2", d2, m_d2);
      chk("state", state, m_state);
      chk("low_batt", low_batt, m_low);
      chk("led", led, led_of(m_soc));
      chk("bbm", (d1 != 0 && d2 != 0), 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_soc(input int v);
    @(negedge clk);
    soc       = 8'(v);
    soc_valid = 1'b1;
    @(negedge clk);
    soc_valid = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; soc = '0; soc_valid = 1'b0; en = 1'b0; load_req = 1'b0; fault_in = 1'b0;
    #12;
    chk("rst_d1", d1, 0);
    chk("rst_d2", d2, 0);
    chk("rst_state", state, 0);
    chk("rst_low", low_batt, 0);
    chk("rst_led", led, 0);
    @(negedge clk);
    rst = 1'b0;

    // Charge ramp
    en = 1'b1;
    send_soc(50);
    cycles(3);
    chk("chg_state", state, 1);
    cycles(1000);
    chk("chg_d1", d1, 90);
    chk("chg_d2", d2, 0);

    // Top-off and complete
    send_soc(96);
    cycles(3);
    chk("top_state", state, 2);
    cycles(700);
    chk("top_d1", d1, 30);
    send_soc(100);
    cycles(3);
    chk("full_state", state, 0);
    cycles(400);
    chk("full_d1", d1, 0);
    send_soc(89);
    cycles(3);
    chk("rechg_state", state, 1);
    cycles(1000);
    chk("rechg_d1", d1, 90);

    // Break-before-make into discharge
    load_req = 1'b1;
    send_soc(60);
    cycles(1900);
    chk("dis_state", state, 3);
    chk("dis_d1", d1, 0);
    chk("dis_d2", d2, 80);

    // Low-battery lockout
    send_soc(20);
    cycles(2);
    chk("lb_state", state, 0);
    chk("lb_flag", low_batt, 1);
    cycles(900);
    chk("lb_d2", d2, 0);
    send_soc(24);
    cycles(5);
    chk("lb24_state", state, 0);
    chk("lb24_flag", low_batt, 1);
    send_soc(25);
    cycles(1);
    chk("lb25_flag", low_batt, 0);
    cycles(3);
    chk("lb25_state", state, 3);

    // Fault at d1 = 45
    load_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (d1 == 8'd45) found = 1'b1;
    end
    chk("fault_reach45", found, 1);
    fault_in = 1'b1;
    @(posedge clk);
    #1;
    chk("fault_state", state, 4);
    chk("fault_d1", d1, 0);
    chk("fault_d2", d2, 0);
    @(negedge clk);
    fault_in = 1'b0;
    cycles(5);
    chk("fault_hold", state, 4);
    en = 1'b0;
    cycles(2);
    chk("fault_exit", state, 0);

    // Asynchronous reset mid-ramp
    en = 1'b1;
    cycles(200);
    chk("pre_rst_ramping", (d1 > 0 && d1 < 90), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_d1", d1, 0);
    chk("mrst_d2", d2, 0);
    chk("mrst_state", state, 0);
    chk("mrst_led", led, 0);
    @(negedge clk);
    rst = 1'b0;

    // SOC clamp
    send_soc(150);
    chk("clamp_led", led, 8'hFF);

    // Randomized operation
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        send_soc((r < 4) ? 255 : $urandom_range(0, 130));
      end else begin
        @(negedge clk);
        if (r < 52)      load_req = ~load_req;
        else if (r < 58) en = ~en;
        else if (r < 62) fault_in = ~fault_in;
      end
      cycles($urandom_range(1, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/charge_duty_ctrl.md
# charge_duty_ctrl

Charge/discharge supervisor that sits directly upstream of the `pwm` block. It takes the SOC estimate (percent) and operator requests and runs a charge / top-off / discharge state machine. It produces slew-limited duty commands `d1` (charger leg) and `d2` (load leg) in percent, 0..100, which drive `pwm` inputs `D1`/`D2`. `d2 == 0` turns `pwm.sw` off.

## Interface
- `CLK_HZ`, 50000000: clock frequency.
- `RAMP_HZ`, 1000: duty step rate, 1 %/step. `TICK_DIV = CLK_HZ/RAMP_HZ`.
- `SOC_LOW`, 20: discharge cutoff (%).
- `SOC_HIGH`, 95: CC-charge to top-off threshold (%).
- `SOC_FULL`, 100: charge-complete level (%).
- `HYST`, 5: hysteresis band (%).
- `D1_MAX`, 90: charge duty target (%).
- `D1_TOP`, 30: top-off duty target (%).
- `D2_MAX`, 80: discharge duty target (%).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `soc` in 8: SOC estimate, percent.
- `soc_valid` in 1: one-cycle strobe; `soc` is valid when high.
- `en` in 1: controller enable (level).
- `load_req` in 1: 1 = discharge into load, 0 = charge (level).
- `fault_in` in 1: external fault (level).
- `d1` out 8: charger duty to `pwm.D1`.
- `d2` out 8: load duty to `pwm.D2`.
- `state` out 3: FSM state code.
- `low_batt` out 1: discharge lockout flag.
- `led` out 8: SOC thermometer bar.

## Operation
- **SOC capture:** on `soc_valid`, `soc_q <= min(soc,100)` and `have_sample <= 1`. The FSM stays in IDLE until `have_sample` is set.
- **Prescaler:** counts 0..TICK_DIV-1 and emits a one-cycle `tick` on wrap.
- **States and codes** (in `battery_ctrl_pkg`): IDLE=0, CHARGE=1, TOPOFF=2, DISCHARGE=3, FAULT=4.
- **Transition priority:** fault_in > en=0 > load_req > SOC thresholds.
  - Any state, `fault_in=1` → FAULT.
  - FAULT → IDLE only when `fault_in=0` and `en=0`, so the operator must cycle `en`.
  - IDLE, `en=1`, `load_req=1`, `!low_batt`, `soc_q>SOC_LOW` → DISCHARGE.
  - IDLE, `en=1`, `load_req=0`: `soc_q<SOC_HIGH` → CHARGE; `SOC_HIGH<=soc_q<SOC_FULL` → TOPOFF; otherwise stay.
  - CHARGE: `en=0` or `load_req=1` → IDLE; `soc_q>=SOC_HIGH` → TOPOFF.
  - TOPOFF: `en=0`, `load_req=1` or `soc_q>=SOC_FULL` → IDLE; `soc_q<SOC_HIGH-HYST` → CHARGE.
  - DISCHARGE: `en=0` or `load_req=0` → IDLE; `soc_q<=SOC_LOW` → IDLE and set `low_batt`.
- **low_batt:** cleared when `soc_q>=SOC_LOW+HYST`.
- **Duty targets:**
  - CHARGE: `d1`→D1_MAX, `d2`→0.
  - TOPOFF: `d1`→D1_TOP, `d2`→0.
  - DISCHARGE: `d2`→D2_MAX, `d1`→0.
  - IDLE: both → 0.
- **Ramping:** on each `tick`, each duty moves 1 toward its target in either direction and holds once equal.
- **Break-before-make:** `d2` may not rise while `d1!=0`, and `d1` may not rise while `d2!=0`.
- **FAULT:** `d1` and `d2` are forced to 0 immediately, with no ramp.
- **LED bar:** `led[i] = (soc_q >= T[i])`, with `T = {12,25,37,50,62,75,87,100}`.
- **Arithmetic:** 8-bit unsigned. Duties are never below 0 or above 100. Threshold compares are unsigned.

## Timing
- **Reset values:** `d1=0`, `d2=0`, `state=0`, `low_batt=0`, `led=0`, `soc_q=0`, `have_sample=0`, prescaler 0.
- **Pipeline:**
  - `soc_valid` at edge N → `soc_q` and `led` valid after edge N.
  - Resulting state change at edge N+1.
  - First duty step at the first `tick` after that.
- **Fault response:** `fault_in` sampled high at edge N → `state=FAULT` and `d1=d2=0` after edge N, within one cycle.
- **Ramp duration:** a full ramp 0→90 takes 90 ticks (90 ms at defaults).
- **Simultaneous events:** a threshold crossing and `tick` in the same cycle ramp toward the old target, then switch targets from the next cycle. `soc_valid` coincident with a transition uses the old `soc_q`.
- **Mid-operation reset:** `rst` asserted mid-ramp clears the duties asynchronously. There is no ramp-down on reset.

## Structure
- **`battery_ctrl_pkg`:** state codes, `PCT_MAX=100`, and LED threshold constants.
- **Sub-module `duty_ramp`:** one instance per channel. Inputs: `clk`, `rst`, `tick`, `target[7:0]`, `hold_up`, `force_zero`. Output: `duty[7:0]`. The FSM and prescaler live in the top level.

## Test plan
Bench uses `CLK_HZ=1000`, `RAMP_HZ=100` (TICK_DIV=10).
- **Charge ramp:** `soc=50`, `en=1`, `load_req=0` → state 1; `d1` rises 1 per 10 clocks to 90 and holds; `d2=0` throughout.
- **Top-off and complete:** from CHARGE, `soc=96` → state 2, `d1` ramps down to 30. Then `soc=100` → state 0 and `d1` ramps to 0. Then `soc=89` with `en=1` → CHARGE.
- **Break-before-make:** charging at `d1=90`, raise `load_req` with `soc=60` → `d2` stays 0 until `d1` reaches 0, then rises to 80 in DISCHARGE.
- **Low-battery lockout:** in DISCHARGE, `soc=20` → IDLE with `low_batt=1` and `d2` ramps to 0. `soc=24` → no re-entry; `soc=25` → `low_batt=0`, DISCHARGE resumes.
- **Fault:** `fault_in=1` at `d1=45` → `d1=d2=0` and `state=4` one clock later. Dropping `fault_in` with `en=1` keeps FAULT; then `en=0` → IDLE.
- **Reset and input limits:** async `rst` mid-ramp → all outputs 0 before the next edge. `soc=150` → `soc_q=100`, `led=8'hFF`.
